uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through byte FIFO; 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// Latency: a byte written at edge N starts its start bit at edge N+1 if idle; writes to a full FIFO are dropped and flagged.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     en,
    input  logic [15:0]              prescaler,
    input  logic [7:0]               wdata,
    input  logic                     wr,
    input  logic                     ovf_clr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);
    localparam int AW = $clog2(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;

    state_t        r_state;
    logic          r_tx;
    logic          r_busy;
    logic [7:0]    r_shift;
    logic [15:0]   r_presc;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bit;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_can_pop;
    logic          w_bit_end;
    logic [7:0]    w_rdata;

    assign w_full    = (r_level == (AW+1)'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = wr && !w_full;
    assign w_can_pop = en && !w_empty;
    assign w_bit_end = (r_cnt == r_presc);
    // A pop both starts a frame from IDLE and chains frames at the end of STOP.
    assign w_pop     = w_can_pop && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    assign w_rdata   = r_mem[r_rptr];

    always_ff @(posedge HCLK) begin
        if (w_push)
            r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A rejected write wins over a simultaneous clear.
            if (wr && w_full)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_presc <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_shift <= w_rdata;
            r_presc <= prescaler;
            r_cnt   <= '0;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^w_rdata;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_ovf;
    assign busy     = r_busy;
    assign tx       = r_tx;

endmodule
